mantissa_add_sub_pipe: RTL and testbench

- Pipelined, parametrised successor of the combinational mantissa adder/subtractor in the FP add/sub datapath.
- Takes aligned sign-magnitude mantissas (hidden bit + mantissa + guard/round/sticky) and an add/sub select.
- Produces a sign-magnitude result with carry-out and zero flag.
- Two register stages with valid/ready handshake on both sides, so the normaliser can stall the adder without losing data.

---
 rtl/mantissa_add_sub_pipe_if.sv | 34 +++
 rtl/mantissa_add_sub_pipe.sv | 114 +++++++++++
 tb/tb_mantissa_add_sub_pipe.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mantissa_add_sub_pipe_if.sv
// Handshake bundle for the pipelined mantissa adder/subtractor.
//   master : operand producer and result consumer (drives in_valid, operands,
//            out_ready; observes in_ready and the result beat)
//   slave  : the adder pipe itself
// MW = MANTISSA_WIDTH + 4 (hidden bit + mantissa + guard/round/sticky).
interface mantissa_add_sub_pipe_if #(
    parameter int MANTISSA_WIDTH = 23
);
    localparam int MW = MANTISSA_WIDTH + 4;

    logic          in_valid;
    logic          in_ready;
    logic [MW-1:0] man_a;
    logic [MW-1:0] man_b;
    logic          ma_sign;
    logic          mb_sign;
    logic          operation_select;
    logic          out_valid;
    logic          out_ready;
    logic [MW-1:0] result;
    logic          carry_out;
    logic          result_sign;
    logic          result_zero;

    modport master (
        output in_valid, man_a, man_b, ma_sign, mb_sign, operation_select, out_ready,
        input  in_ready, out_valid, result, carry_out, result_sign, result_zero
    );

    modport slave (
        input  in_valid, man_a, man_b, ma_sign, mb_sign, operation_select, out_ready,
        output in_ready, out_valid, result, carry_out, result_sign, result_zero
    );
endinterface

// File: rtl/mantissa_add_sub_pipe.sv
// Two-stage pipelined sign-magnitude mantissa adder/subtractor.
//   S1 converts both aligned magnitudes to two's complement (B's sign folded
//   with the add/sub select); S2 adds, and converts back to sign-magnitude
//   with carry-out and zero flag.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset
//   bus  - slave side of mantissa_add_sub_pipe_if: operand beat in
//          (in_valid/in_ready), result beat out (out_valid/out_ready)
module mantissa_add_sub_pipe #(
    parameter int MANTISSA_WIDTH = 23,
    parameter int SIGNED_WIDTH   = MANTISSA_WIDTH + 6
) (
    input  logic                    clk,
    input  logic                    rst,
    mantissa_add_sub_pipe_if.slave  bus
);
    localparam int MW = MANTISSA_WIDTH + 4;

    // ---------------- flow control ----------------
    logic s1_valid;
    logic out_valid_q;
    logic s1_adv;
    logic s2_adv;

    // Each stage is a single-entry register; a stage may load whenever its
    // successor is empty or draining this cycle.
    assign s2_adv       = !out_valid_q || bus.out_ready;
    assign s1_adv       = !s1_valid || s2_adv;
    assign bus.in_ready = s1_adv;

    // ---------------- stage 1: to two's complement ----------------
    logic                    eff_b_sign;
    logic [SIGNED_WIDTH-1:0] ext_a;
    logic [SIGNED_WIDTH-1:0] ext_b;
    logic [SIGNED_WIDTH-1:0] in_sa;
    logic [SIGNED_WIDTH-1:0] in_sb;

    // Subtraction is addition of B with its sign flipped.
    assign eff_b_sign = bus.mb_sign ^ ~bus.operation_select;
    assign ext_a      = {2'b00, bus.man_a};
    assign ext_b      = {2'b00, bus.man_b};
    assign in_sa      = bus.ma_sign ? (~ext_a + 1'b1) : ext_a;
    assign in_sb      = eff_b_sign  ? (~ext_b + 1'b1) : ext_b;

    logic [SIGNED_WIDTH-1:0] s1_sa;
    logic [SIGNED_WIDTH-1:0] s1_sb;
    logic                    s1_zsign;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sa    <= '0;
            s1_sb    <= '0;
            s1_zsign <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sa    <= in_sa;
                s1_sb    <= in_sb;
                // An exact-zero sum is -0 only when both effective operands are negative.
                s1_zsign <= bus.ma_sign & eff_b_sign;
            end
        end
    end

    // ---------------- stage 2: add, back to sign-magnitude ----------------
    logic [SIGNED_WIDTH-1:0] sum;
    logic [MW:0]             sum_lo;
    logic                    sum_neg;
    logic [MW:0]             mag;
    logic                    mag_zero;
    logic                    sum_sign;

    // Two extra bits of headroom: |sa + sb| < 2^(MW+1), so the sum never
    // overflows and the low MW+1 bits of its negation are the exact magnitude.
    assign sum      = s1_sa + s1_sb;
    assign sum_lo   = sum[MW:0];
    assign sum_neg  = sum[SIGNED_WIDTH-1];
    assign mag      = sum_neg ? (~sum_lo + 1'b1) : sum_lo;
    assign mag_zero = (mag == '0);
    assign sum_sign = mag_zero ? s1_zsign : sum_neg;

    logic [MW-1:0] result_q;
    logic          carry_q;
    logic          sign_q;
    logic          zero_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            sign_q      <= 1'b0;
            zero_q      <= 1'b0;
        end else if (s2_adv) begin
            out_valid_q <= s1_valid;
            // Bubbles leave the last result in place.
            if (s1_valid) begin
                result_q <= mag[MW-1:0];
                carry_q  <= mag[MW];
                sign_q   <= sum_sign;
                zero_q   <= mag_zero;
            end
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.result      = result_q;
    assign bus.carry_out   = carry_q;
    assign bus.result_sign = sign_q;
    assign bus.result_zero = zero_q;

endmodule

// File: tb/tb_mantissa_add_sub_pipe.sv
module tb_mantissa_add_sub_pipe;
    localparam int MANTISSA_WIDTH = 23;
    localparam int MW             = MANTISSA_WIDTH + 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mantissa_add_sub_pipe_if #(.MANTISSA_WIDTH(MANTISSA_WIDTH)) bus ();

    mantissa_add_sub_pipe #(.MANTISSA_WIDTH(MANTISSA_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [MW-1:0] res;
        logic          carry;
        logic          sign;
        logic          zero;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   last_acc;

    logic [MW-1:0] ba [5];
    logic [MW-1:0] bb [5];
    bit            bsa[5];
    bit            bsb[5];
    bit            bop[5];

    // Reference: signed integer arithmetic straight from the sign-magnitude rules.
    function automatic exp_t model(longint a, longint b, bit sa, bit sb, bit op);
        bit     eneg = sb ^ !op;
        longint va   = sa ? -a : a;
        longint vb   = eneg ? -b : b;
        longint s    = va + vb;
        longint m    = (s < 0) ? -s : s;
        exp_t   e;
        e.res   = m[MW-1:0];
        e.carry = m[MW];
        e.zero  = (m == 0);
        e.sign  = (s < 0) ? 1'b1 : (s > 0) ? 1'b0 : (sa & eneg);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [MW-1:0] a, input logic [MW-1:0] b,
                         input bit sa, input bit sb, input bit op, input bit v);
        bus.man_a            = a;
        bus.man_b            = b;
        bus.ma_sign          = sa;
        bus.mb_sign          = sb;
        bus.operation_select = op;
        bus.in_valid         = v;
    endtask

    // One clock: score the output beat against the model, record acceptance,
    // then advance past the edge.
    task automatic tick();
        #1;
        last_acc = bus.in_valid && bus.in_ready;
        if (bus.out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_out", {63'b0, bus.out_valid}, 64'd0);
            end else begin
                exp_t e = q[0];
                chk("out_result", {37'b0, bus.result}, {37'b0, e.res});
                chk("out_carry",  {63'b0, bus.carry_out},   {63'b0, e.carry});
                chk("out_sign",   {63'b0, bus.result_sign}, {63'b0, e.sign});
                chk("out_zero",   {63'b0, bus.result_zero}, {63'b0, e.zero});
                if (bus.out_ready) void'(q.pop_front());
            end
        end
        if (last_acc)
            q.push_back(model(longint'(bus.man_a), longint'(bus.man_b),
                              bus.ma_sign, bus.mb_sign, bus.operation_select));
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [MW-1:0] a, input logic [MW-1:0] b,
                            input bit sa, input bit sb, input bit op,
                            input logic [MW-1:0] xres, input bit xc, input bit xs, input bit xz);
        bus.out_ready = 1'b1;
        drive(a, b, sa, sb, op, 1'b1);
        tick();
        drive(a, b, sa, sb, op, 1'b0);
        chk({tag, "_lat1"}, {63'b0, bus.out_valid}, 64'd0);
        tick();
        chk({tag, "_lat2"},  {63'b0, bus.out_valid},   64'd1);
        chk({tag, "_res"},   {37'b0, bus.result},      {37'b0, xres});
        chk({tag, "_carry"}, {63'b0, bus.carry_out},   {63'b0, xc});
        chk({tag, "_sign"},  {63'b0, bus.result_sign}, {63'b0, xs});
        chk({tag, "_zero"},  {63'b0, bus.result_zero}, {63'b0, xz});
        tick();
    endtask

    task automatic rand_beat(output logic [MW-1:0] a, output logic [MW-1:0] b,
                             output bit sa, output bit sb, output bit op);
        a  = MW'($urandom);
        b  = MW'($urandom);
        if ($urandom_range(0, 7) == 0) b = a;
        if ($urandom_range(0, 15) == 0) a = '0;
        if ($urandom_range(0, 15) == 0) b = '0;
        if ($urandom_range(0, 15) == 0) begin a = '1; b = '1; end
        sa = 1'($urandom);
        sb = 1'($urandom);
        op = 1'($urandom);
    endtask

    initial begin
        logic [MW-1:0] ra, rb;
        bit rsa, rsb, rop;
        int sent;

        rst = 1'b1;
        bus.out_ready = 1'b0;
        drive('0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        chk("rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
        chk("rst_result",    {37'b0, bus.result},    64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rel_in_ready",  {63'b0, bus.in_ready},    64'd1);
        chk("rel_out_valid", {63'b0, bus.out_valid},   64'd0);
        chk("rel_result",    {37'b0, bus.result},      64'd0);
        chk("rel_carry",     {63'b0, bus.carry_out},   64'd0);
        chk("rel_sign",      {63'b0, bus.result_sign}, 64'd0);
        chk("rel_zero",      {63'b0, bus.result_zero}, 64'd0);
        tick();
        chk("idle_out_valid", {63'b0, bus.out_valid}, 64'd0);

        // Directed arithmetic cases
        directed("add_basic", 27'd100, 27'd30, 0, 0, 1, 27'd130, 0, 0, 0);
        directed("sub_neg",   27'd30, 27'd100, 0, 0, 0, 27'd70, 0, 1, 0);
        directed("carry",     27'h7FFFFFF, 27'h7FFFFFF, 0, 0, 1, 27'h7FFFFFE, 1, 0, 0);
        directed("neg_a_sub", 27'd50, 27'd50, 1, 0, 0, 27'd100, 0, 1, 0);
        directed("zero_pos",  27'd50, 27'd50, 0, 0, 0, 27'd0, 0, 0, 1);
        directed("zero_neg",  27'd0, 27'd0, 1, 1, 1, 27'd0, 0, 1, 1);
        directed("zero_mix",  27'd0, 27'd0, 1, 0, 1, 27'd0, 0, 0, 1);

        // Back-to-back stream, no backpressure
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k < 5) begin
                rand_beat(ra, rb, rsa, rsb, rop);
                drive(ra, rb, rsa, rsb, rop, 1'b1);
                chk("stream_in_ready", {63'b0, bus.in_ready}, 64'd1);
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
            chk("stream_out_valid", {63'b0, bus.out_valid}, {63'b0, (k + 1 >= 2) && (k + 1 <= 6)});
        end
        chk("stream_drained", 64'(q.size()), 64'd0);

        // Stall: capacity 2, then drain in order
        for (int i = 0; i < 5; i++) rand_beat(ba[i], bb[i], bsa[i], bsb[i], bop[i]);
        bus.out_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 6; c++) begin
            drive(ba[sent], bb[sent], bsa[sent], bsb[sent], bop[sent], 1'b1);
            tick();
            if (last_acc) sent++;
            chk("stall_in_ready", {63'b0, bus.in_ready}, {63'b0, sent < 2});
        end
        chk("stall_accepted", 64'(sent), 64'd2);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 30 && !(sent == 5 && q.size() == 0); c++) begin
            if (sent < 5) drive(ba[sent], bb[sent], bsa[sent], bsb[sent], bop[sent], 1'b1);
            else          bus.in_valid = 1'b0;
            tick();
            if (last_acc) sent++;
        end
        chk("stall_all_sent", 64'(sent), 64'd5);
        chk("stall_drained",  64'(q.size()), 64'd0);

        // Reset with two beats in flight
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rand_beat(ra, rb, rsa, rsb, rop);
            drive(ra, rb, rsa, rsb, rop, 1'b1);
            tick();
        end
        bus.in_valid = 1'b0;
        chk("pre_rst_out_valid", {63'b0, bus.out_valid}, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", {63'b0, bus.out_valid},   64'd0);
        chk("async_rst_result",    {37'b0, bus.result},      64'd0);
        chk("async_rst_zero",      {63'b0, bus.result_zero}, 64'd0);
        q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_out_valid", {63'b0, bus.out_valid}, 64'd0);
        end

        // Randomized traffic with random backpressure
        bus.in_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!bus.in_valid || last_acc) begin
                rand_beat(ra, rb, rsa, rsb, rop);
                drive(ra, rb, rsa, rsb, rop, $urandom_range(0, 3) != 0);
            end
            bus.out_ready = $urandom_range(0, 3) != 0;
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10 && q.size() != 0; c++) tick();
        chk("rand_drained", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
